// File: rtl/dmem_if.sv
// Load/store bus between the datapath LSU (master) and the data-memory controller (slave).
interface dmem_if;
    logic        req;
    logic        we;
    logic [2:0]  funct3;
    logic [31:0] a;
    logic [31:0] wd;
    logic        ready;
    logic        rsp_valid;
    logic [31:0] rd;
    logic        fault;

    modport master (output req, we, funct3, a, wd, input ready, rsp_valid, rd, fault);
    modport slave  (input req, we, funct3, a, wd, output ready, rsp_valid, rd, fault);
endinterface

// File: rtl/dmem_ctrl.sv
// Byte-addressed data memory with RISC-V load/store sizing, fault detection and
// a configurable number of wait states between accept and response.
module dmem_ctrl #(
    parameter int unsigned MEM_WORDS = 4096,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          RD_LAT    = 0
) (
    input  logic  clk,
    input  logic  reset,
    dmem_if.slave bus
);
    localparam int unsigned BYTES    = MEM_WORDS * 4;
    localparam int unsigned AW       = $clog2(BYTES);
    localparam logic [2:0]  LAT_INIT = (RD_LAT == 0) ? 3'd0 : 3'(RD_LAT - 1);

    generate
        if (RD_LAT < 0 || RD_LAT > 7) begin : g_bad_lat
            $error("dmem_ctrl: RD_LAT must be within 0..7");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t        state_q, state_d;
    logic [2:0]    count_q, count_d;
    logic [31:0]   rd_q;
    logic          fault_q;
    logic [7:0]    mem [BYTES];

    logic [31:0]   off;
    logic [2:0]    size_m1;
    logic [32:0]   last;
    logic          bad_f3, misaligned, out_of_range, bad;
    logic          ready, accept;
    logic [AW-1:0] idx;
    logic [7:0]    b0, b1, b2, b3;
    logic [31:0]   load_val;

    // Request decode; the 33-bit last-byte offset cannot wrap back into range.
    always_comb begin
        off = bus.a - BASE_ADDR;
        case (bus.funct3[1:0])
            2'd0:    size_m1 = 3'd0;
            2'd1:    size_m1 = 3'd1;
            default: size_m1 = 3'd3;
        endcase
        bad_f3       = (bus.funct3 == 3'd3) || (bus.funct3[2:1] == 2'b11) ||
                       (bus.we && bus.funct3[2]);
        misaligned   = ((size_m1 == 3'd1) && bus.a[0]) ||
                       ((size_m1 == 3'd3) && (bus.a[1:0] != 2'b00));
        last         = {1'b0, off} + {30'd0, size_m1};
        out_of_range = (last >= 33'(BYTES));
        bad          = bad_f3 || misaligned || out_of_range;
    end

    assign idx    = off[AW-1:0];
    assign ready  = (state_q == IDLE) && !reset;
    assign accept = bus.req && ready;

    always_comb begin
        b0 = mem[idx];
        b1 = mem[idx + AW'(1)];
        b2 = mem[idx + AW'(2)];
        b3 = mem[idx + AW'(3)];
        case (bus.funct3)
            3'd0:    load_val = {{24{b0[7]}}, b0};
            3'd1:    load_val = {{16{b1[7]}}, b1, b0};
            3'd2:    load_val = {b3, b2, b1, b0};
            3'd4:    load_val = {24'd0, b0};
            3'd5:    load_val = {16'd0, b1, b0};
            default: load_val = '0;
        endcase
    end

    // NOTE: the storage array has no reset branch; reset only clears control state,
    // so stores committed before a reset stay in memory.
    always_ff @(posedge clk) begin
        if (accept && bus.we && !bad) begin
            mem[idx] <= bus.wd[7:0];
            if (size_m1 != 3'd0) mem[idx + AW'(1)] <= bus.wd[15:8];
            if (size_m1 == 3'd3) begin
                mem[idx + AW'(2)] <= bus.wd[23:16];
                mem[idx + AW'(3)] <= bus.wd[31:24];
            end
        end
    end

    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values
    // regardless of the order in which processes execute.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            count_q <= 3'd0;
            rd_q    <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            if (accept) begin
                rd_q    <= (bus.we || bad) ? 32'd0 : load_val;
                fault_q <= bad;
            end
        end
    end

    // NOTE: next-state outputs get defaults before the case so no path leaves them
    // unassigned, which would otherwise infer latches.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = (RD_LAT == 0) ? RESP : WAIT;
                    count_d = LAT_INIT;
                end
            end
            WAIT: begin
                if (count_q == 3'd0) state_d = RESP;
                else                 count_d = count_q - 3'd1;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign bus.ready     = ready;
    assign bus.rsp_valid = (state_q == RESP);
    assign bus.rd        = rd_q;
    assign bus.fault     = fault_q;
endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed and randomised checks of dmem_ctrl at RD_LAT 0, 2 and 3 against
// hand-computed values and a byte-array reference model.
module tb_dmem_ctrl;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req = 1'b0, we = 1'b0;
    logic [2:0]  f3 = 3'd0;
    logic [31:0] a = '0, wd = '0;
    int          sel = 0;
    int          passed = 0, failed = 0, total = 0;
    int          acc [4] = '{0, 0, 0, 0};
    int          rsp [4] = '{0, 0, 0, 0};
    logic [7:0]  ref0 [256];
    logic [7:0]  ref2 [64];

    always #5 clk = ~clk;

    dmem_if bus0 ();
    dmem_if bus2 ();
    dmem_if bus3 ();

    assign bus0.req = req && (sel == 0);
    assign bus2.req = req && (sel == 2);
    assign bus3.req = req && (sel == 3);
    assign bus0.we = we;      assign bus2.we = we;      assign bus3.we = we;
    assign bus0.funct3 = f3;  assign bus2.funct3 = f3;  assign bus3.funct3 = f3;
    assign bus0.a = a;        assign bus2.a = a;        assign bus3.a = a;
    assign bus0.wd = wd;      assign bus2.wd = wd;      assign bus3.wd = wd;

    dmem_ctrl #(.MEM_WORDS(64), .BASE_ADDR(32'h0000_0000), .RD_LAT(0)) u0 (.clk(clk), .reset(reset), .bus(bus0));
    dmem_ctrl #(.MEM_WORDS(16), .BASE_ADDR(32'h0000_0100), .RD_LAT(2)) u2 (.clk(clk), .reset(reset), .bus(bus2));
    dmem_ctrl #(.MEM_WORDS(64), .BASE_ADDR(32'h0000_0000), .RD_LAT(3)) u3 (.clk(clk), .reset(reset), .bus(bus3));

    function automatic logic cur_ready();
        case (sel) 0: return bus0.ready; 2: return bus2.ready; default: return bus3.ready; endcase
    endfunction
    function automatic logic cur_rsp();
        case (sel) 0: return bus0.rsp_valid; 2: return bus2.rsp_valid; default: return bus3.rsp_valid; endcase
    endfunction
    function automatic logic [31:0] cur_rd();
        case (sel) 0: return bus0.rd; 2: return bus2.rd; default: return bus3.rd; endcase
    endfunction
    function automatic logic cur_fault();
        case (sel) 0: return bus0.fault; 2: return bus2.fault; default: return bus3.fault; endcase
    endfunction

    // Count accepts and responses per instance, well clear of both clock edges.
    always begin
        @(negedge clk);
        #2;
        if (bus0.req && bus0.ready) acc[0]++;
        if (bus2.req && bus2.ready) acc[2]++;
        if (bus3.req && bus3.ready) acc[3]++;
        if (bus0.rsp_valid) rsp[0]++;
        if (bus2.rsp_valid) rsp[2]++;
        if (bus3.rsp_valid) rsp[3]++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge of the response cycle.
    task automatic do_req(input int s, input logic w, input logic [2:0] f, input logic [31:0] addr,
                          input logic [31:0] data, output logic [31:0] r, output logic flt, output int lat);
        int n = 0;
        sel = s; we = w; f3 = f; a = addr; wd = data; req = 1'b1;
        while (!cur_ready() && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("ready_wait", 32'(cur_ready()), 32'd1);
        @(posedge clk);
        @(negedge clk);
        req = 1'b0;
        lat = 1;
        while (!cur_rsp() && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        r = cur_rd();
        flt = cur_fault();
    endtask

    task automatic xfer(input string tag, input int s, input logic w, input logic [2:0] f,
                        input logic [31:0] addr, input logic [31:0] data,
                        input logic [31:0] exp_rd, input logic exp_flt);
        logic [31:0] r;
        logic        flt;
        int          lat;
        do_req(s, w, f, addr, data, r, flt, lat);
        check({tag, "_rd"}, r, exp_rd);
        check({tag, "_fault"}, 32'(flt), 32'(exp_flt));
        check({tag, "_lat"}, 32'(lat), 32'(s + 1));
    endtask

    // Reference model: decides the fault, applies the store, returns the load value.
    task automatic model(input int s, input logic w, input logic [2:0] f, input logic [31:0] addr,
                         input logic [31:0] data, output logic [31:0] exp_rd, output logic exp_flt);
        logic [31:0] base = (s == 0) ? 32'h0 : 32'h100;
        longint      bytes = (s == 0) ? 256 : 64;
        logic [31:0] off = addr - base;
        int          size = (f[1:0] == 2'd0) ? 1 : (f[1:0] == 2'd1) ? 2 : 4;
        logic [31:0] v = '0;
        exp_flt = (f == 3'd3) || (f == 3'd6) || (f == 3'd7) || (w && f[2]) ||
                  (size == 2 && addr[0]) || (size == 4 && addr[1:0] != 2'b00) ||
                  (longint'(off) + size > bytes);
        exp_rd = '0;
        if (exp_flt) return;
        for (int i = 0; i < size; i++) begin
            if (w) begin
                if (s == 0) ref0[int'(off) + i] = data[8*i +: 8];
                else        ref2[int'(off) + i] = data[8*i +: 8];
            end else begin
                v[8*i +: 8] = (s == 0) ? ref0[int'(off) + i] : ref2[int'(off) + i];
            end
        end
        if (!w) begin
            case (f)
                3'd0:    exp_rd = {{24{v[7]}}, v[7:0]};
                3'd1:    exp_rd = {{16{v[15]}}, v[15:0]};
                default: exp_rd = v;
            endcase
        end
    endtask

    task automatic run_op(input string tag, input int s, input logic w, input logic [2:0] f,
                          input logic [31:0] addr, input logic [31:0] data);
        logic [31:0] er;
        logic        ef;
        model(s, w, f, addr, data, er, ef);
        xfer(tag, s, w, f, addr, data, er, ef);
    endtask

    initial begin
        int snap;
        logic [2:0]  rf;
        logic        rw;
        logic [31:0] ra;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        sel = 0;
        check("rst_ready_low", 32'(cur_ready()), 32'd0);
        check("rst_rsp_low", 32'(cur_rsp()), 32'd0);
        check("rst_rd_zero", cur_rd(), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("rel_ready_high", 32'(cur_ready()), 32'd1);

        // RD_LAT=0: word, byte and half accesses with extension
        xfer("sw10",    0, 1'b1, 3'd2, 32'h10, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0);
        xfer("lw10",    0, 1'b0, 3'd2, 32'h10, 32'h0,         32'hDEAD_BEEF, 1'b0);
        xfer("lb13",    0, 1'b0, 3'd0, 32'h13, 32'h0,         32'hFFFF_FFDE, 1'b0);
        xfer("lbu13",   0, 1'b0, 3'd4, 32'h13, 32'h0,         32'h0000_00DE, 1'b0);
        xfer("lh10",    0, 1'b0, 3'd1, 32'h10, 32'h0,         32'hFFFF_BEEF, 1'b0);
        xfer("lhu12",   0, 1'b0, 3'd5, 32'h12, 32'h0,         32'h0000_DEAD, 1'b0);
        xfer("sb11",    0, 1'b1, 3'd0, 32'h11, 32'hAAAA_AA55, 32'h0000_0000, 1'b0);
        xfer("lw10_sb", 0, 1'b0, 3'd2, 32'h10, 32'h0,         32'hDEAD_55EF, 1'b0);

        // Faults
        xfer("lw12_mis", 0, 1'b0, 3'd2, 32'h12,  32'h0,    32'h0, 1'b1);
        xfer("sh11_mis", 0, 1'b1, 3'd1, 32'h11,  32'h1234, 32'h0, 1'b1);
        xfer("f3_3",     0, 1'b0, 3'd3, 32'h10,  32'h0,    32'h0, 1'b1);
        xfer("sbu_st",   0, 1'b1, 3'd4, 32'h10,  32'h77,   32'h0, 1'b1);
        xfer("lw10_kept",0, 1'b0, 3'd2, 32'h10,  32'h0,    32'hDEAD_55EF, 1'b0);
        xfer("sw_top",   0, 1'b1, 3'd2, 32'hFC,  32'hCAFE_F00D, 32'h0, 1'b0);
        xfer("lw_top",   0, 1'b0, 3'd2, 32'hFC,  32'h0,    32'hCAFE_F00D, 1'b0);
        xfer("lh_top",   0, 1'b0, 3'd1, 32'hFE,  32'h0,    32'hFFFF_CAFE, 1'b0);
        xfer("lb_top",   0, 1'b0, 3'd0, 32'hFF,  32'h0,    32'hFFFF_FFCA, 1'b0);
        xfer("lw_end",   0, 1'b0, 3'd2, 32'h100, 32'h0,    32'h0, 1'b1);
        xfer("lb_end",   0, 1'b0, 3'd0, 32'h100, 32'h0,    32'h0, 1'b1);

        // RD_LAT=2 with a non-zero base address
        xfer("b_below",  2, 1'b0, 3'd2, 32'hFC,        32'h0, 32'h0, 1'b1);
        xfer("b_sw",     2, 1'b1, 3'd2, 32'h13C,       32'h0BAD_F00D, 32'h0, 1'b0);
        xfer("b_lw",     2, 1'b0, 3'd2, 32'h13C,       32'h0, 32'h0BAD_F00D, 1'b0);
        xfer("b_end",    2, 1'b0, 3'd2, 32'h140,       32'h0, 32'h0, 1'b1);
        xfer("b_wrap",   2, 1'b0, 3'd2, 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b1);

        // RD_LAT=3: ready low four cycles, held request accepted only after RESP
        sel = 3; we = 1'b1; f3 = 3'd2; a = 32'h40; wd = 32'h11; req = 1'b1;
        check("l3_ready_idle", 32'(cur_ready()), 32'd1);
        @(posedge clk);
        @(negedge clk);
        we = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            check($sformatf("l3_ready_c%0d", k), 32'(cur_ready()), 32'd0);
            check($sformatf("l3_rsp_c%0d", k), 32'(cur_rsp()), 32'(k == 4));
            if (k == 4) check("l3_sw_rd", cur_rd(), 32'd0);
            @(negedge clk);
        end
        check("l3_ready_back", 32'(cur_ready()), 32'd1);
        @(posedge clk);
        @(negedge clk);
        req = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            check($sformatf("l3_ld_rsp_c%0d", k), 32'(cur_rsp()), 32'(k == 4));
            if (k == 4) check("l3_lw_rd", cur_rd(), 32'h11);
            @(negedge clk);
        end
        check("l3_accepts", 32'(acc[3]), 32'd2);

        // Reset during WAIT of a store
        sel = 3; we = 1'b1; f3 = 3'd2; a = 32'h20; wd = 32'h1234_5678; req = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req = 1'b0;
        check("rw_in_wait", 32'(cur_ready()), 32'd0);
        reset = 1'b1;
        snap = rsp[3];
        @(posedge clk);
        @(negedge clk);
        check("rw_ready", 32'(cur_ready()), 32'd0);
        check("rw_rsp", 32'(cur_rsp()), 32'd0);
        check("rw_rd", cur_rd(), 32'd0);
        check("rw_fault", 32'(cur_fault()), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rw_rel_ready", 32'(cur_ready()), 32'd1);
        repeat (5) @(negedge clk);
        check("rw_dropped", 32'(rsp[3]), 32'(snap));
        xfer("rw_lw20", 3, 1'b0, 3'd2, 32'h20, 32'h0, 32'h1234_5678, 1'b0);

        // Preload both random targets, then random back-to-back traffic
        for (int i = 0; i < 64; i++) run_op("pre0", 0, 1'b1, 3'd2, 32'(4 * i), $urandom);
        for (int i = 0; i < 16; i++) run_op("pre2", 2, 1'b1, 3'd2, 32'h100 + 32'(4 * i), $urandom);
        for (int s = 0; s <= 2; s += 2) begin
            for (int i = 0; i < 120; i++) begin
                case ($urandom_range(0, 5))
                    0: rf = 3'd0;  1: rf = 3'd1;  2: rf = 3'd2;
                    3: rf = 3'd4;  4: rf = 3'd5;  default: rf = 3'd3;
                endcase
                rw = 1'($urandom_range(0, 1));
                if (rw && rf[2] && $urandom_range(0, 3) != 0) rf[2] = 1'b0;
                if (s == 0) ra = 32'($urandom_range(0, 263));
                else        ra = 32'h100 - 32'd8 + 32'($urandom_range(0, 79));
                if ($urandom_range(0, 3) != 0) begin
                    if (rf[1:0] == 2'd1)      ra[0] = 1'b0;
                    else if (rf[1:0] != 2'd0) ra[1:0] = 2'b00;
                end
                run_op($sformatf("rnd%0d_%0d", s, i), s, rw, rf, ra, $urandom);
            end
        end

        repeat (3) @(negedge clk);
        check("one_rsp_u0", 32'(rsp[0]), 32'(acc[0]));
        check("one_rsp_u2", 32'(rsp[2]), 32'(acc[2]));
        check("one_rsp_u3", 32'(rsp[3]), 32'(acc[3] - 1));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/dmem_ctrl.md
Name: dmem_ctrl

Overview:
- Parametrised byte-addressed data memory with a request/response handshake.
- Accepts RISC-V load/store size codes (funct3).
- Performs byte/halfword/word access with sign or zero extension.
- Flags misaligned, out-of-range and illegal accesses.
- Inserts a configurable number of wait states before each response.
- Sits between the datapath LSU and the data RAM.
- Supersedes the fixed word-only, combinational-read memory.

Parameters:
- MEM_WORDS, 4096: memory depth in 32-bit words; byte capacity is MEM_WORDS*4.
- BASE_ADDR, 32'h0000_0000: byte address mapped to RAM byte 0.
- RD_LAT, 0: extra wait cycles between accept and response; legal range 0..7.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- req  input  1  request valid.
- we  input  1  1 = store, 0 = load; sampled with req.
- funct3  input  3  access size/sign: 0 B, 1 H, 2 W, 4 BU, 5 HU.
- a  input  32  byte address.
- wd  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- ready  output  1  block can accept a request this cycle.
- rsp_valid  output  1  one-cycle pulse: response valid.
- rd  output  32  load result, extended to 32 bits; 0 for stores and faults.
- fault  output  1  qualified by rsp_valid: access rejected.

Behaviour:
- Storage is byte array MEM_WORDS*4 deep, little-endian. Contents are not reset and have no initialisation requirement.
- Offset off = a - BASE_ADDR (32-bit, wraps). Access is in range iff off + size - 1 < MEM_WORDS*4 and off >= 0 unsigned; any a below BASE_ADDR wraps huge and is out of range.
- Fault conditions, evaluated at accept:
  - funct3 in {3,6,7}.
  - Store with funct3 4 or 5.
  - H/HU with a[0]=1.
  - W with a[1:0]!=0.
  - Out of range.
- A faulting request writes nothing, returns rd=0 and fault=1.
- FSM has three states: IDLE, WAIT, RESP.
  - IDLE: ready=1. Accept = req&&ready at the rising edge.
    - Store: byte lanes are written at the accept edge (1, 2 or 4 bytes).
    - Load: data is read and extended at the accept edge into a result register.
    - Go to RESP if RD_LAT=0, else WAIT with count=RD_LAT-1.
  - WAIT: ready=0. Count decrements each cycle; at count 0 go to RESP.
  - RESP: ready=0, rsp_valid=1, rd/fault driven from registers. Always return to IDLE next cycle.
- Latency: accept at edge N gives rsp_valid high during cycle N+1+RD_LAT. Back-to-back throughput is one request per RD_LAT+2 cycles.
- Ordering: store committed at accept, so an immediately following load to the same address returns the new data.
- Extension rules:
  - LB sign-extends bit 7; LBU zero-extends.
  - LH sign-extends bit 15; LHU zero-extends.
  - LW is unmodified.
- Store rd is 0 and fault is 0 when legal.
- req while ready=0 is ignored, not queued. The requester holds req until it sees ready.
- rd and fault hold their last value outside RESP, but only rsp_valid qualifies them.
- Reset (synchronous, active-high), applied any cycle:
  - Next state IDLE; rsp_valid=0, rd=0, fault=0, count=0; ready=0 while reset is high, 1 the cycle after release.
  - In-flight response is dropped; a store already committed is retained.
  - req during reset is not accepted.
- RD_LAT outside 0..7 is a configuration error; elaboration fails.

Test Plan:
- RD_LAT=0: SW a=0x10 wd=0xDEADBEEF, then LW a=0x10 → rsp_valid one cycle after each accept; LW rd=0xDEADBEEF, fault=0.
- Byte/half extension after the word above:
  - LB a=0x13 → 0xFFFFFFDE.
  - LBU a=0x13 → 0x000000DE.
  - LH a=0x10 → 0xFFFFBEEF.
  - LHU a=0x12 → 0x0000DEAD.
  - SB a=0x11 wd=0x55 then LW a=0x10 → 0xDEAD55EF.
- Faults:
  - LW a=0x12, SH a=0x11, and funct3=3 each give fault=1, rd=0.
  - LW at the word after a faulting SH is unchanged.
  - LW a=BASE_ADDR+MEM_WORDS*4 gives fault=1.
  - LW a=BASE_ADDR+MEM_WORDS*4-4 gives fault=0.
- RD_LAT=3: accept at edge N → ready low for cycles N+1..N+4, rsp_valid exactly at cycle N+4; a req held through WAIT is accepted only after RESP.
- Reset asserted during WAIT of an SW a=0x20 wd=0x12345678 → no rsp_valid; after release, LW a=0x20 returns 0x12345678.
- Back-to-back random loads/stores (RD_LAT=0 and 2) vs byte-array reference model → every response matches; exactly one rsp_valid per accepted request.
